// File: rtl/cu_pkg.sv
// Shared encodings for the control_unit sequencer: states, opcodes, datapath
// select codes and function codes.
package cu_pkg;

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH_L,
    S_FETCH_H,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_MOV = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BRA = 4'h7;
  localparam logic [3:0] OP_BNE = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_AR = 2'b01;
  localparam logic [1:0] ARF_SP = 2'b10;

  localparam logic [3:0] ARF_EN_PC = 4'b1000;
  localparam logic [3:0] ARF_EN_AR = 4'b0100;
  localparam logic [3:0] ARF_EN_SP = 4'b0010;

  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_ADD    = 4'b0100;
  localparam logic [3:0] ALU_SUB    = 4'b0110;
  localparam logic [3:0] ALU_AND    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;

  // RF read port code for general register n (R1..R4 -> n = 0..3)
  function automatic logic [2:0] rf_sel(input logic [1:0] n);
    return {1'b1, n};
  endfunction

  // RF one-hot write enable for general register n
  function automatic logic [3:0] rf_en(input logic [1:0] n);
    return 4'b1000 >> n;
  endfunction

  // ALU function for the two-operand arithmetic/logic opcodes
  function automatic logic [3:0] alu_fun(input logic [3:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      default: return ALU_PASS_A;
    endcase
  endfunction

endpackage

// File: rtl/cu_step_timer.sv
// Micro-step timer: counts clocks within a step and flags the final one,
// where register loads and memory writes are strobed.
module cu_step_timer #(
  parameter int unsigned STEP_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  output logic last_cycle
);

  localparam int unsigned CW = $clog2(STEP_CYCLES);

  logic [CW-1:0] cyc;

  assign last_cycle = (cyc == CW'(STEP_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || last_cycle) cyc <= '0;
    else                     cyc <= cyc + CW'(1);
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer for ALU_System: fetches a 16-bit instruction in two
// bytes, decodes it and drives the datapath selects for each micro-step.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 3
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ALU_ZCNO,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic [1:0]  IR_Funsel,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        InstrDone,
  output logic        Illegal,
  output logic        Halted
);

  state_t state, next_state;
  logic   last_cycle;

  logic [3:0] op;
  logic       am;
  logic [1:0] rd, rs;
  logic       zero;
  logic       unused_bits;

  assign op   = IR_Out[15:12];
  assign am   = IR_Out[11];
  assign rd   = IR_Out[9:8];
  assign rs   = IR_Out[1:0];
  assign zero = ALU_ZCNO[3];
  assign unused_bits = ^{IR_Out[10], IR_Out[7:2], ALU_ZCNO[2:0]};

  cu_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk        (Clock),
    .reset      (Reset),
    .last_cycle (last_cycle)
  );

  // State advances only at step boundaries; reset wins at any cycle.
  always_ff @(posedge Clock) begin
    if (Reset)           state <= S_INIT;
    else if (last_cycle) state <= next_state;
  end

  // Step intents, turned into final-cycle strobes below.
  logic rd_load, ar_load, pc_load, mem_write, done, bad;

  always_comb begin
    MuxASel     = 2'b00;
    MuxBSel     = 2'b00;
    MuxCSel     = 1'b0;
    RF_OutASel  = 3'b000;
    RF_OutBSel  = 3'b000;
    RF_FunSel   = 2'b00;
    RF_RSel     = 4'b0000;
    RF_TSel     = 4'b0000;
    ALU_FunSel  = 4'b0000;
    ARF_OutASel = 2'b00;
    ARF_OutBSel = 2'b00;
    ARF_FunSel  = 2'b00;
    ARF_RSel    = 4'b0000;
    IR_Funsel   = 2'b00;
    IR_Enable   = 1'b0;
    IR_LH       = 1'b0;
    Mem_WR      = 1'b0;
    Mem_CS      = 1'b1;
    InstrDone   = 1'b0;
    Illegal     = 1'b0;
    Halted      = 1'b0;
    next_state  = state;
    rd_load     = 1'b0;
    ar_load     = 1'b0;
    pc_load     = 1'b0;
    mem_write   = 1'b0;
    done        = 1'b0;
    bad         = 1'b0;

    case (state)
      S_INIT: begin
        ARF_FunSel = FUN_CLR;
        RF_FunSel  = FUN_CLR;
        if (last_cycle) begin
          ARF_RSel = ARF_EN_PC | ARF_EN_AR | ARF_EN_SP;
          RF_RSel  = 4'b1111;
        end
        next_state = S_FETCH_L;
      end

      S_FETCH_L, S_FETCH_H: begin
        Mem_CS      = 1'b0;
        ARF_OutBSel = ARF_PC;
        IR_Funsel   = FUN_LOAD;
        IR_LH       = (state == S_FETCH_H);
        ARF_FunSel  = FUN_INC;
        if (last_cycle) begin
          IR_Enable = 1'b1;
          ARF_RSel  = ARF_EN_PC;
        end
        next_state = (state == S_FETCH_L) ? S_FETCH_H : S_EXEC1;
      end

      S_EXEC1: begin
        next_state = S_FETCH_L;
        case (op)
          OP_AND, OP_OR, OP_ADD, OP_SUB: begin
            RF_OutASel = rf_sel(rd);
            RF_OutBSel = rf_sel(rs);
            ALU_FunSel = alu_fun(op);
            rd_load    = 1'b1;
            done       = 1'b1;
          end
          OP_MOV: begin
            RF_OutASel = rf_sel(rs);
            ALU_FunSel = ALU_PASS_A;
            rd_load    = 1'b1;
            done       = 1'b1;
          end
          OP_LD, OP_ST: begin
            if (am && op == OP_LD) begin
              MuxASel = 2'b10;
              rd_load = 1'b1;
              done    = 1'b1;
            end else if (am) begin
              bad = 1'b1;
            end else begin
              // direct mode: latch the address into AR first
              MuxBSel    = 2'b10;
              ar_load    = 1'b1;
              next_state = S_EXEC2;
            end
          end
          OP_BRA: begin
            MuxBSel = 2'b10;
            pc_load = 1'b1;
            done    = 1'b1;
          end
          OP_BNE: begin
            MuxBSel = 2'b10;
            pc_load = ~zero;
            done    = 1'b1;
          end
          OP_HLT:  next_state = S_HALT;
          default: bad = 1'b1;
        endcase
      end

      S_EXEC2: begin
        ARF_OutBSel = ARF_AR;
        Mem_CS      = 1'b0;
        if (op == OP_ST) begin
          RF_OutASel = rf_sel(rd);
          ALU_FunSel = ALU_PASS_A;
          mem_write  = 1'b1;
        end else begin
          MuxASel = 2'b01;
          rd_load = 1'b1;
        end
        done       = 1'b1;
        next_state = S_FETCH_L;
      end

      S_HALT: Halted = 1'b1;

      default: next_state = S_INIT;
    endcase

    if (rd_load)            RF_FunSel  = FUN_LOAD;
    if (ar_load || pc_load) ARF_FunSel = FUN_LOAD;
    if (last_cycle) begin
      if (rd_load) RF_RSel  = rf_en(rd);
      if (ar_load) ARF_RSel = ARF_EN_AR;
      if (pc_load) ARF_RSel = ARF_EN_PC;
      Mem_WR    = mem_write;
      InstrDone = done;
      Illegal   = bad;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: drives IR_Out/ALU_ZCNO as the datapath
// would and checks the per-step controls against hand-computed values.
module tb_control_unit;

  localparam int unsigned SC = 3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IR_Out;
  logic [3:0]  ALU_ZCNO;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel;
  logic [3:0]  ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic [1:0]  IR_Funsel;
  logic        IR_Enable, IR_LH, Mem_WR, Mem_CS;
  logic        InstrDone, Illegal, Halted;

  int n_chk  = 0;
  int n_pass = 0;

  control_unit #(.STEP_CYCLES(SC)) dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ALU_ZCNO(ALU_ZCNO),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable),
    .IR_LH(IR_LH), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS),
    .InstrDone(InstrDone), .Illegal(Illegal), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  function automatic logic [9:0] strobes();
    return {RF_RSel, ARF_RSel, IR_Enable, Mem_WR};
  endfunction

  // From FETCH_L cycle 0 through both fetch steps; leaves us at EXEC1 cycle 0.
  task automatic fetch(input logic [15:0] ir);
    chk("fl_cs",    16'(Mem_CS), 16'h0);
    chk("fl_outb",  16'(ARF_OutBSel), 16'h0);
    chk("fl_lh",    16'(IR_LH), 16'h0);
    chk("fl_en_c0", 16'(IR_Enable), 16'h0);
    tick(SC - 1);
    chk("fl_en",    16'(IR_Enable), 16'h1);
    chk("fl_pc",    16'(ARF_RSel), 16'h8);
    chk("fl_inc",   16'(ARF_FunSel), 16'h1);
    tick(1);
    chk("fh_lh",    16'(IR_LH), 16'h1);
    IR_Out = ir;
    tick(SC - 1);
    chk("fh_en",    16'(IR_Enable), 16'h1);
    tick(1);
  endtask

  initial begin : main
    int wr;
    int ill;
    logic [9:0] acc;
    logic hbad;

    Reset = 1'b1; IR_Out = 16'h0000; ALU_ZCNO = 4'b0000;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_strobes", 16'(strobes()), 16'h0);
    chk("rst_cs",      16'(Mem_CS), 16'h1);
    chk("rst_flags",   16'({InstrDone, Illegal, Halted}), 16'h0);
    chk("init_fun",    16'({ARF_FunSel, RF_FunSel}), 16'hF);
    Reset = 1'b0;
    tick(SC - 1);
    chk("init_rf",  16'(RF_RSel), 16'hF);
    chk("init_arf", 16'(ARF_RSel), 16'hE);
    tick(1);

    // LD R1 #0x5A
    fetch(16'h585A);
    chk("ld_muxa",   16'(MuxASel), 16'h2);
    chk("ld_rs_c0",  16'(RF_RSel), 16'h0);
    chk("ld_done_0", 16'(InstrDone), 16'h0);
    tick(SC - 1);
    chk("ld_rsel",   16'(RF_RSel), 16'h8);
    chk("ld_done",   16'(InstrDone), 16'h1);
    tick(1);

    // ADD R2,R1
    fetch(16'h2100);
    chk("add_outa", 16'(RF_OutASel), 16'h5);
    chk("add_outb", 16'(RF_OutBSel), 16'h4);
    chk("add_alu",  16'(ALU_FunSel), 16'h4);
    chk("add_rs_0", 16'(RF_RSel), 16'h0);
    tick(SC - 1);
    chk("add_rsel", 16'(RF_RSel), 16'h4);
    chk("add_done", 16'(InstrDone), 16'h1);
    tick(1);

    // ST R1 -> [0x80]
    fetch(16'h6080);
    chk("st1_muxb", 16'(MuxBSel), 16'h2);
    chk("st1_ar_0", 16'(ARF_RSel), 16'h0);
    tick(SC - 1);
    chk("st1_ar",   16'(ARF_RSel), 16'h4);
    chk("st1_done", 16'(InstrDone), 16'h0);
    tick(1);
    chk("st2_outb", 16'(ARF_OutBSel), 16'h1);
    chk("st2_cs",   16'(Mem_CS), 16'h0);
    chk("st2_outa", 16'(RF_OutASel), 16'h4);
    wr = 0;
    for (int i = 0; i < int'(SC); i++) begin
      wr += int'(Mem_WR);
      if (i == int'(SC) - 1) begin
        chk("st2_wr_last", 16'(Mem_WR), 16'h1);
        chk("st2_done",    16'(InstrDone), 16'h1);
      end
      tick(1);
    end
    chk("st2_wr_count", 16'(wr), 16'h1);

    // BNE taken-not: Z = 1
    ALU_ZCNO = 4'b1000;
    fetch(16'h8010);
    tick(SC - 1);
    chk("bne_z_arf",  16'(ARF_RSel), 16'h0);
    chk("bne_z_done", 16'(InstrDone), 16'h1);
    tick(1);
    // BNE taken: Z = 0
    ALU_ZCNO = 4'b0000;
    fetch(16'h8010);
    chk("bne_muxb", 16'(MuxBSel), 16'h2);
    tick(SC - 1);
    chk("bne_arf",  16'(ARF_RSel), 16'h8);
    tick(1);

    // Undefined opcode A
    fetch(16'hA000);
    acc = '0; ill = 0;
    for (int i = 0; i < int'(SC); i++) begin
      acc |= strobes();
      ill += int'(Illegal);
      if (i == int'(SC) - 1) chk("ill_last", 16'(Illegal), 16'h1);
      tick(1);
    end
    chk("ill_count",   16'(ill), 16'h1);
    chk("ill_strobes", 16'(acc), 16'h0);
    chk("ill_to_fetch", 16'({Mem_CS, IR_Funsel, IR_LH}), 16'h4);

    // HLT holds until reset
    fetch(16'hF000);
    tick(SC);
    chk("halted", 16'(Halted), 16'h1);
    hbad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (strobes() != '0 || Halted !== 1'b1 || Mem_CS !== 1'b1) hbad = 1'b1;
      tick(1);
    end
    chk("halt_hold", 16'(hbad), 16'h0);

    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("halt_exit", 16'(Halted), 16'h0);
    tick(SC);          // FETCH_L
    tick(SC + 1);      // FETCH_H cycle 1
    chk("mid_fh", 16'(IR_LH), 16'h1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("mid_rst_strobes", 16'(strobes()), 16'h0);
    chk("mid_rst_cs",      16'(Mem_CS), 16'h1);
    tick(SC - 1);
    chk("mid_rst_rf",  16'(RF_RSel), 16'hF);
    chk("mid_rst_arf", 16'(ARF_RSel), 16'hE);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
